// File: rtl/data_memory_pkg.sv
// Shared types and sizing helpers for the wait-stated data memory controller.
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ADDR_W = 32;
  // Wide enough for the largest supported WAIT_STATES value (15).
  localparam int CNT_W  = 4;

  function automatic int byte_cnt(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a requester (master) and the memory controller (slave).
interface data_memory_ctrl_if #(
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_memory_array.sv
// Word-organised storage with per-byte write enables, combinational read and async clear.
module data_memory_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-outstanding memory controller: accept, wait WAIT_STATES cycles, then respond.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// BUSY  | legal access in progress, wait counter running down
// RESP  | response presented until rsp_ready
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  data_memory_ctrl_if.slave bus
);

  localparam int BYTES  = byte_cnt(DATA_W);
  localparam int OFF_W  = off_w(DATA_W);
  localparam int IDX_W  = idx_w(DEPTH);
  localparam int SPAN_W = IDX_W + OFF_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BYTES-1:0]    be_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                error_q;
  logic [DATA_W-1:0]   mem_rdata;

  logic accept;
  logic fault_in;
  logic commit;

  assign accept   = bus.req_valid && (state_q == IDLE);
  // Misaligned, or any address bit above the array span set.
  assign fault_in = ((bus.req_addr & OFF_MASK) != '0) || ((bus.req_addr >> SPAN_W) != '0);
  assign commit   = (state_q == BUSY) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fault_in) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= bus.req_write;
        idx_q   <= IDX_W'(bus.req_addr >> OFF_W);
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
        if (fault_in) begin
          rdata_q <= '0;
          error_q <= 1'b1;
        end
      end
      if (commit) begin
        rdata_q <= write_q ? '0 : mem_rdata;
        error_q <= 1'b0;
      end
    end
  end

  data_memory_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (commit && write_q),
    .be    (be_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: transaction-level memory model plus per-cycle output compare.
module tb_data_memory_ctrl;

  localparam int WS = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  data_memory_ctrl_if #(.DATA_W(32)) bus   ();
  data_memory_ctrl_if #(.DATA_W(32)) bus0  ();
  data_memory_ctrl_if #(.DATA_W(32)) bus15 ();

  data_memory_ctrl #(.DATA_W(32), .DEPTH(32), .WAIT_STATES(WS)) u_dut (
    .clock (clock), .reset (reset), .bus (bus)
  );
  data_memory_ctrl #(.DATA_W(32), .DEPTH(32), .WAIT_STATES(0)) u_dut0 (
    .clock (clock), .reset (reset), .bus (bus0)
  );
  data_memory_ctrl #(.DATA_W(32), .DEPTH(32), .WAIT_STATES(15)) u_dut15 (
    .clock (clock), .reset (reset), .bus (bus15)
  );

  // Shared stimulus for the two latency-sweep instances.
  logic        x_valid = 1'b0;
  logic        x_write = 1'b0;
  logic [31:0] x_addr  = '0;
  logic [31:0] x_wdata = '0;
  logic [3:0]  x_be    = '0;

  assign bus0.req_valid  = x_valid;
  assign bus0.req_write  = x_write;
  assign bus0.req_addr   = x_addr;
  assign bus0.req_wdata  = x_wdata;
  assign bus0.req_be     = x_be;
  assign bus0.rsp_ready  = 1'b1;
  assign bus15.req_valid = x_valid;
  assign bus15.req_write = x_write;
  assign bus15.req_addr  = x_addr;
  assign bus15.req_wdata = x_wdata;
  assign bus15.req_be    = x_be;
  assign bus15.rsp_ready = 1'b1;

  // Transaction-level model of the main instance.
  logic [31:0] mem_model [32];
  bit          pending = 1'b0;
  int          resp_at = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    end else begin
      chk("req_ready", 32'(bus.req_ready), 32'(!pending));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(pending && (cyc >= resp_at)));
      if (pending && (cyc >= resp_at)) begin
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
        chk("rsp_error", 32'(bus.rsp_error), 32'(exp_err));
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem_model[i] = '0;
    pending = 1'b0;
  endtask

  task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int stall, input int lit_lat,
                      input logic [31:0] lit_rdata, input bit lit_err);
    bit fault;
    int idx;
    int acc;
    int lat_m;
    bit seen;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    @(posedge clock); #1;
    acc   = cyc;
    fault = (addr[1:0] != 2'b00) || (addr >= 32'd128);
    idx   = int'(addr[6:2]);
    exp_err   = fault;
    exp_rdata = (fault || wr) ? 32'd0 : mem_model[idx];
    if (!fault && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_model[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    resp_at = acc + (fault ? 0 : WS + 1);
    pending = 1'b1;
    if (stall > 0) begin
      // Keep a different request asserted; it must be ignored until after the handshake.
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h0000_0004;
      bus.req_wdata = 32'hFFFF_FFFF;
      bus.req_be    = 4'hF;
    end else begin
      bus.req_valid = 1'b0;
    end
    seen  = 1'b0;
    lat_m = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus.rsp_valid) begin
        seen  = 1'b1;
        lat_m = cyc - acc;
      end else begin
        @(posedge clock); #1;
      end
    end
    if (!seen) begin
      failures++;
      checks++;
      $display("FAIL rsp_timeout addr=%h actual=no_response required=response", addr);
    end
    chk("latency", 32'(lat_m), 32'(lit_lat));
    chk("lit_rdata", bus.rsp_rdata, lit_rdata);
    chk("lit_error", 32'(bus.rsp_error), 32'(lit_err));
    repeat (stall) begin
      @(posedge clock); #1;
    end
    if (stall > 0) chk("stall_rdata", bus.rsp_rdata, lit_rdata);
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    pending       = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic probe(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat0, output int lat15,
                       output logic [31:0] rd0, output logic [31:0] rd15);
    int acc;
    int k;
    x_valid = 1'b1;
    x_write = wr;
    x_addr  = addr;
    x_wdata = wd;
    x_be    = 4'hF;
    @(posedge clock); #1;
    acc     = cyc;
    x_valid = 1'b0;
    lat0    = -1;
    lat15   = -1;
    rd0     = 'x;
    rd15    = 'x;
    k       = 0;
    while ((lat0 < 0 || lat15 < 0) && k < 40) begin
      if (bus0.rsp_valid && lat0 < 0) begin
        lat0 = cyc - acc;
        rd0  = bus0.rsp_rdata;
      end
      if (bus15.rsp_valid && lat15 < 0) begin
        lat15 = cyc - acc;
        rd15  = bus15.rsp_rdata;
      end
      if (lat0 < 0 || lat15 < 0) begin
        @(posedge clock); #1;
      end
      k++;
    end
    @(posedge clock); #1;
  endtask

  initial begin
    int l0, l15;
    logic [31:0] r0, r15;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b1;

    // Basic write/read with full byte enables.
    xact(1'b1, 32'h08, 32'h0000_0037, 4'hF, 0, 3, 32'h0, 1'b0);
    xact(1'b0, 32'h08, 32'h0,         4'h0, 0, 3, 32'h0000_0037, 1'b0);
    // Partial byte-enable merge.
    xact(1'b1, 32'h04, 32'h1122_3344, 4'hF, 0, 3, 32'h0, 1'b0);
    xact(1'b1, 32'h04, 32'hAABB_CCDD, 4'h5, 0, 3, 32'h0, 1'b0);
    xact(1'b0, 32'h04, 32'h0,         4'h0, 0, 3, 32'h11BB_33DD, 1'b0);
    // Faults respond immediately and leave memory untouched.
    xact(1'b0, 32'h06, 32'h0,         4'h0, 0, 0, 32'h0, 1'b1);
    xact(1'b0, 32'h80, 32'h0,         4'h0, 0, 0, 32'h0, 1'b1);
    xact(1'b1, 32'h06, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 1'b1);
    xact(1'b1, 32'h84, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 1'b1);
    xact(1'b0, 32'h04, 32'h0,         4'h0, 0, 3, 32'h11BB_33DD, 1'b0);
    // Zero byte-enable write is a normal no-op completion.
    xact(1'b1, 32'h10, 32'h1234_5678, 4'hF, 0, 3, 32'h0, 1'b0);
    xact(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 3, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 32'h0,         4'h0, 0, 3, 32'h1234_5678, 1'b0);
    // Backpressured response with a competing request held high.
    xact(1'b0, 32'h08, 32'h0,         4'h0, 5, 3, 32'h0000_0037, 1'b0);
    // Last word of the array.
    xact(1'b1, 32'h7C, 32'hCAFE_F00D, 4'hF, 0, 3, 32'h0, 1'b0);
    xact(1'b0, 32'h7C, 32'h0,         4'h0, 0, 3, 32'hCAFE_F00D, 1'b0);

    // Reset during BUSY aborts the write and clears memory.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0C;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_be    = 4'hF;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    pending = 1'b1;
    resp_at = cyc + WS + 1;
    @(posedge clock); #1;
    chk("busy_req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    clear_model();
    #1;
    chk("async_req_ready", 32'(bus.req_ready), 32'd1);
    chk("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    xact(1'b0, 32'h0C, 32'h0, 4'h0, 0, 3, 32'h0, 1'b0);
    xact(1'b0, 32'h08, 32'h0, 4'h0, 0, 3, 32'h0, 1'b0);

    // Latency sweep on the WAIT_STATES=0 and 15 instances.
    probe(1'b1, 32'h00, 32'h5A5A_1234, l0, l15, r0, r15);
    chk("ws0_wr_latency", 32'(l0), 32'd1);
    chk("ws15_wr_latency", 32'(l15), 32'd16);
    probe(1'b0, 32'h00, 32'h0, l0, l15, r0, r15);
    chk("ws0_rd_latency", 32'(l0), 32'd1);
    chk("ws15_rd_latency", 32'(l15), 32'd16);
    chk("ws0_rd_data", r0, 32'h5A5A_1234);
    chk("ws15_rd_data", r15, 32'h5A5A_1234);

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of words (power of 2).
REQ-003 The block SHALL have parameter WAIT_STATES, default 2, meaning extra access cycles (0..15).
REQ-004 The block SHALL have port clock, input, 1, the single clock, rising-edge active.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1, meaning a request is present.
REQ-007 The block SHALL have port req_ready, output, 1, meaning the block can accept a request.
REQ-008 The block SHALL have port req_write, input, 1, with 1 = write and 0 = read.
REQ-009 The block SHALL have port req_addr, input, 32, the byte address.
REQ-010 The block SHALL have port req_wdata, input, DATA_W, the write data.
REQ-011 The block SHALL have port req_be, input, DATA_W/8, the byte enables for writes.
REQ-012 The block SHALL have port rsp_valid, output, 1, meaning a response is present.
REQ-013 The block SHALL have port rsp_ready, input, 1, meaning the consumer accepts the response.
REQ-014 The block SHALL have port rsp_rdata, output, DATA_W, the read data (0 for writes and errors).
REQ-015 The block SHALL have port rsp_error, output, 1, flagging an access fault.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, BUSY and RESP, with req_ready=1 only in IDLE and rsp_valid=1 only in RESP.
REQ-017 A request SHALL be accepted at a rising edge with req_valid=1 and req_ready=1; write, addr, wdata and be are registered at that edge, and inputs are ignored outside acceptance.
REQ-018 On acceptance the FSM SHALL go to BUSY, and a wait counter SHALL load WAIT_STATES.
REQ-019 In BUSY the counter SHALL decrement each cycle, and the FSM SHALL go to RESP at the edge where the counter equals 0.
REQ-020 rsp_valid SHALL therefore rise exactly WAIT_STATES+1 edges after the accept edge.
REQ-021 Word index SHALL be addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)].
REQ-022 A fault SHALL be either misalignment (addr low log2(DATA_W/8) bits nonzero) or out of range (addr >= DEPTH*DATA_W/8).
REQ-023 A faulting request SHALL skip BUSY: the FSM goes IDLE->RESP at the next edge with rsp_error=1 and rsp_rdata=0, and memory is unchanged.
REQ-024 A legal write SHALL update only bytes with be=1, at the BUSY->RESP edge.
REQ-025 A legal read SHALL register the word into rsp_rdata at the BUSY->RESP edge.
REQ-026 A write with be all 0 SHALL complete normally with rsp_error=0 and no memory change.
REQ-027 rsp_valid, rsp_rdata and rsp_error SHALL hold stable in RESP until an edge with rsp_ready=1, then the FSM goes to IDLE.
REQ-028 No request SHALL be accepted in that same edge; the minimum request spacing is WAIT_STATES+3 cycles.
REQ-029 A read following a write to the same word SHALL return the merged new data.

Reset
REQ-030 Reset low SHALL force IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, and all memory words to 0, asynchronously.
REQ-031 Reset asserted mid-BUSY SHALL abort the access: no write is committed and no response is produced.
REQ-032 The first request SHALL be accepted at the first edge after reset deasserts.

Structure
REQ-033 Package data_memory_pkg SHALL hold the state enum (IDLE/BUSY/RESP) and helper constants (byte count, index width, byte-offset width).
REQ-034 The storage array with per-byte write enables and async clear SHALL be a sub-module named data_memory_array; the FSM, counter and fault decode stay in data_memory_ctrl.

Verification
REQ-035 Reset, then write addr 0x8, wdata 0x00000037, be 0xF, then read 0x8 -> rsp_rdata 0x00000037, rsp_error 0, rsp_valid rising 3 edges after each accept (WAIT_STATES=2).
REQ-036 Preload 0x11223344 at 0x4, write 0xAABBCCDD with be 0x5, then read -> 0x11BB33DD.
REQ-037 Read 0x6 (misaligned) and read 0x80 (out of range, DEPTH=32) -> rsp_error=1, rsp_rdata=0, rsp_valid at the first edge after accept, memory unchanged.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, and a new req_valid is not accepted until after the rsp_ready handshake.
REQ-039 Write 0xFFFFFFFF to 0xC, pulse reset low during BUSY, then read 0xC -> 0x00000000, and no response is emitted for the aborted write.
REQ-040 Sweep WAIT_STATES=0 and 15 -> response latency 1 and 16 edges respectively.
